mem_port_arbiter: RTL and testbench

- Shares the single-port data RAM between the multi-cycle CPU and a secondary requester (DMA/program loader).
- Sits between the CPU memory interface and the RAM port (addra/dina/wea/douta).
- Generates the CPU's MIO_ready handshake.
- Sequences each access through a small FSM: grant, issue, read-latency wait, response.
- Uses round-robin arbitration.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sharing of one single-port data RAM between the
//               CPU and a secondary (DMA/loader) requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              grant
);

    localparam int         c_CNT_W = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we_flag;
    logic               r_last_grant;
    logic               r_grant;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_ram_we;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_dma_rdata;
    logic               r_cpu_ready;
    logic               r_dma_ready;

    // Secondary wins when it is the only requester, or on a tie when the CPU
    // owned the port last.
    logic w_win_dma;
    assign w_win_dma = dma_req & (~cpu_req | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we_flag    <= 1'b0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b1;
            r_busy       <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_ready  <= 1'b0;
            r_dma_ready  <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            r_ram_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req || dma_req) begin
                        r_grant    <= w_win_dma;
                        r_ram_addr <= w_win_dma ? dma_addr  : cpu_addr;
                        r_ram_din  <= w_win_dma ? dma_wdata : cpu_wdata;
                        r_we_flag  <= w_win_dma ? dma_we    : cpu_we;
                        r_ram_we   <= w_win_dma ? dma_we    : cpu_we;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we_flag) begin
                        r_cpu_ready <= ~r_grant;
                        r_dma_ready <= r_grant;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt   <= c_CNT_W'(RD_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_grant) begin
                            r_dma_rdata <= ram_dout;
                        end else begin
                            r_cpu_rdata <= ram_dout;
                        end
                        r_cpu_ready <= ~r_grant;
                        r_dma_ready <= r_grant;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign cpu_ready = r_cpu_ready;
    assign dma_ready = r_dma_ready;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;
    assign busy      = r_busy;
    assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter (RD_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_din, ram_dout;
    logic        cpu_ready, dma_ready, ram_we, busy, grant;

    logic        c3_req;
    logic [31:0] c3_addr, c3_rdata, c3_ram_addr, c3_ram_din, c3_ram_dout;
    logic [31:0] c3_dma_rdata;
    logic        c3_ready, c3_dma_ready, c3_ram_we, c3_busy, c3_grant;

    int tests_run = 0;
    int tests_failed = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .busy(busy), .grant(grant)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(32'h0),
        .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(c3_dma_rdata), .dma_ready(c3_dma_ready),
        .ram_addr(c3_ram_addr), .ram_din(c3_ram_din), .ram_we(c3_ram_we),
        .ram_dout(c3_ram_dout), .busy(c3_busy), .grant(c3_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM model, 16 words decoded from addr[5:2]
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[5:2]] <= ram_din;
        ram_dout <= mem[ram_addr[5:2]];
    end

    // Three-cycle-latency read-only model returning addr ^ A5A5A5A5
    logic [31:0] p3_0, p3_1;
    always @(posedge clk) begin
        p3_0        <= c3_ram_addr ^ 32'hA5A5_A5A5;
        p3_1        <= p3_0;
        c3_ram_dout <= p3_1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        c3_req = 0; c3_addr = 0;
        step(); step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_din", ram_din, 32'h0);
        check("rst_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
        check("rst_rdata", cpu_rdata | dma_rdata, 32'h0);

        // CPU write 0x10 <- DEADBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        step();
        check("wr_issue_we", 32'(ram_we), 32'd1);
        check("wr_issue_addr", ram_addr, 32'h10);
        check("wr_issue_din", ram_din, 32'hDEADBEEF);
        check("wr_issue_grant", 32'(grant), 32'd0);
        check("wr_issue_busy", 32'(busy), 32'd1);
        check("wr_issue_ready", 32'(cpu_ready), 32'd0);
        step();
        check("wr_resp_we", 32'(ram_we), 32'd0);
        check("wr_resp_cpu_ready", 32'(cpu_ready), 32'd1);
        check("wr_resp_dma_ready", 32'(dma_ready), 32'd0);
        cpu_req = 0; cpu_we = 0;
        step();
        check("wr_idle_ready", 32'(cpu_ready), 32'd0);
        check("wr_idle_busy", 32'(busy), 32'd0);

        // CPU read 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        step();
        check("rd_issue_we", 32'(ram_we), 32'd0);
        step();
        check("rd_wait_we", 32'(ram_we), 32'd0);
        check("rd_wait_ready", 32'(cpu_ready), 32'd0);
        check("rd_wait_addr", ram_addr, 32'h10);
        step();
        check("rd_resp_ready", 32'(cpu_ready), 32'd1);
        check("rd_resp_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_resp_dma_rdata", dma_rdata, 32'h0);
        check("rd_resp_we", 32'(ram_we), 32'd0);
        cpu_req = 0;
        step();

        // Contention from reset: both writing, strict alternation CPU first
        rst = 1; step(); rst = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hC0C0C0C0;
        dma_req = 1; dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'hD0D0D0D0;
        for (int k = 0; k < 8; k++) begin
            logic exp_g;
            exp_g = k[0];
            step();
            check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_g));
            check($sformatf("rr_busy_%0d", k), 32'(busy), 32'd1);
            step();
            check($sformatf("rr_ready_%0d", k), {30'd0, cpu_ready, dma_ready},
                  exp_g ? 32'd1 : 32'd2);
            step();
            check($sformatf("rr_gap_%0d", k), 32'(busy), 32'd0);
        end
        cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
        step();
        check("rr_mem_cpu", mem[8], 32'hC0C0C0C0);
        check("rr_mem_dma", mem[9], 32'hD0D0D0D0);

        // DMA read 0x10 to give dma_rdata a known value
        dma_req = 1; dma_we = 0; dma_addr = 32'h10;
        step();
        check("dr_grant", 32'(grant), 32'd1);
        step(); step();
        check("dr_ready", {30'd0, cpu_ready, dma_ready}, 32'd1);
        check("dr_rdata", dma_rdata, 32'hDEADBEEF);
        dma_req = 0;
        step();

        // DMA write 0x4 <- 12345678, then CPU reads it back
        dma_req = 1; dma_we = 1; dma_addr = 32'h4; dma_wdata = 32'h12345678;
        step();
        check("dw_din", ram_din, 32'h12345678);
        step();
        check("dw_ready", 32'(dma_ready), 32'd1);
        dma_req = 0; dma_we = 0;
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
        step(); step(); step();
        check("cr_ready", 32'(cpu_ready), 32'd1);
        check("cr_rdata", cpu_rdata, 32'h12345678);
        check("cr_dma_rdata_held", dma_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        step();

        // Reset during WAIT of a CPU read
        cpu_req = 1; cpu_addr = 32'h10;
        step(); step();
        check("ab_in_wait", 32'(busy), 32'd1);
        rst = 1; cpu_req = 0;
        step();
        rst = 0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_ready", 32'(cpu_ready), 32'd0);
        check("ab_rdata", cpu_rdata, 32'h0);
        check("ab_we", 32'(ram_we), 32'd0);
        check("ab_dma_rdata", dma_rdata, 32'h0);
        step();
        check("ab_ready_later", 32'(cpu_ready), 32'd0);
        cpu_req = 1; dma_req = 1; dma_we = 0; dma_addr = 32'h4;
        step();
        check("ab_tie_cpu_wins", 32'(grant), 32'd0);
        step(); step();
        check("ab_tie_cpu_ready", 32'(cpu_ready), 32'd1);
        cpu_req = 0;
        step();
        step();
        check("ab_dma_next", 32'(grant), 32'd1);
        step(); step();
        check("ab_dma_rdata_got", dma_rdata, 32'h12345678);
        dma_req = 0;
        step();
        rst = 1; step(); rst = 0;
        dma_req = 1;
        step();
        check("ab_dma_alone", 32'(grant), 32'd1);
        dma_req = 0;
        step(); step(); step();

        // RD_LAT = 3 instance
        c3_req = 1; c3_addr = 32'h40;
        step();
        check("l3_issue_busy", 32'(c3_busy), 32'd1);
        for (int w = 0; w < 3; w++) begin
            step();
            check($sformatf("l3_wait_addr_%0d", w), c3_ram_addr, 32'h40);
            check($sformatf("l3_wait_ready_%0d", w), 32'(c3_ready), 32'd0);
        end
        step();
        check("l3_ready", 32'(c3_ready), 32'd1);
        check("l3_rdata", c3_rdata, 32'hA5A5A5E5);
        c3_req = 0;
        step();
        check("l3_idle", 32'(c3_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
